// File: rtl/bp_fpga_host_nbf_tx_arbiter.sv
// Arbitrates NBF packet sources onto the single UART TX packet path, one registered output stage.
// Optional per-requester grant statistics: define BP_FPGA_HOST_NBF_ARB_STATS_EN.
module bp_fpga_host_nbf_tx_arbiter #(
   parameter int num_req_p      = 2,
   parameter int nbf_width_p    = 112,
   parameter int starve_limit_p = 8
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_req_p*nbf_width_p-1:0] req_data_i,
   input  logic [num_req_p-1:0]             req_v_i,
   output logic [num_req_p-1:0]             req_ready_and_o,
   output logic [nbf_width_p-1:0]           data_o,
   output logic                             v_o,
   input  logic                             ready_and_i,
   output logic [$clog2(num_req_p)-1:0]     grant_id_o
`ifdef BP_FPGA_HOST_NBF_ARB_STATS_EN
   ,output logic [num_req_p*16-1:0]         grant_cnt_o
`endif
);

   localparam int IW = $clog2(num_req_p);
   localparam int CW = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;
   localparam logic [CW-1:0] LIM = CW'(starve_limit_p);

   logic [IW-1:0]          r_last_grant;
   logic [CW-1:0]          r_starve_cnt;
   logic [IW-1:0]          w_fix_id, w_fair_id, w_win_id;
   logic [num_req_p-1:0]   w_win_oh;
   logic [nbf_width_p-1:0] w_win_data;
   logic                   w_fair_mode, w_space, w_accept, w_contend;
   int                     w_idx;

   assign w_fair_mode = (starve_limit_p != 0) && (r_starve_cnt == LIM);
   assign w_space     = ~v_o | ready_and_i;

   always_comb begin
      w_fix_id = '0;
      for (int i = num_req_p - 1; i >= 0; i--)
         if (req_v_i[i]) w_fix_id = IW'(i);
   end

   // Scan downward in distance so the nearest valid requester after the last grant wins.
   always_comb begin
      w_fair_id = r_last_grant;
      w_idx     = 0;
      for (int k = num_req_p; k >= 1; k--) begin
         w_idx = int'(r_last_grant) + k;
         if (w_idx >= num_req_p) w_idx = w_idx - num_req_p;
         if (req_v_i[w_idx]) w_fair_id = IW'(w_idx);
      end
   end

   assign w_win_id = w_fair_mode ? w_fair_id : w_fix_id;

   always_comb begin
      w_win_oh   = '0;
      w_win_data = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (w_win_id == IW'(i)) begin
            w_win_oh[i] = 1'b1;
            w_win_data  = req_data_i[i*nbf_width_p +: nbf_width_p];
         end
      end
   end

   assign w_accept        = reset_n_i & w_space & req_v_i[w_win_id];
   assign w_contend       = |(req_v_i & ~w_win_oh);
   assign req_ready_and_o = w_accept ? w_win_oh : '0;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_o        <= 1'b0;
         data_o     <= '0;
         grant_id_o <= '0;
      end else if (w_accept) begin
         v_o        <= 1'b1;
         data_o     <= w_win_data;
         grant_id_o <= w_win_id;
      end else if (ready_and_i) begin
         v_o        <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_last_grant <= IW'(num_req_p - 1);
         r_starve_cnt <= '0;
      end else if (w_accept) begin
         r_last_grant <= w_win_id;
         if (starve_limit_p == 0)
            r_starve_cnt <= '0;
         else if (!w_fair_mode && w_contend) begin
            if (r_starve_cnt != LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
         end else
            r_starve_cnt <= '0;
      end
   end

`ifdef BP_FPGA_HOST_NBF_ARB_STATS_EN
   for (genvar g = 0; g < num_req_p; g++) begin : g_stats
      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i)
            grant_cnt_o[g*16 +: 16] <= '0;
         else if (w_accept && w_win_oh[g] && (grant_cnt_o[g*16 +: 16] != 16'hFFFF))
            grant_cnt_o[g*16 +: 16] <= grant_cnt_o[g*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bp_fpga_host_nbf_tx_arbiter.sv
// Scoreboard bench for the NBF TX arbiter: driver pushes expected packets, monitor pops on handshake.
module tb_bp_fpga_host_nbf_tx_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [223:0] req_data;
   logic [1:0]   req_v, rdy_oh;
   logic [111:0] data;
   logic         v, ready;
   logic [0:0]   gid;

   logic [223:0] fx_data;
   logic [1:0]   fx_v, fx_rdy_oh;
   logic [111:0] fx_dout;
   logic         fx_vo;
   logic [0:0]   fx_gid;
`ifdef BP_FPGA_HOST_NBF_ARB_STATS_EN
   logic [31:0]  gcnt, fx_gcnt;
`endif

   int n_vec = 0, n_err = 0, seq = 0;
   logic [112:0] q[$];

   always #5 clk = ~clk;

   bp_fpga_host_nbf_tx_arbiter u_dut (
      .clk_i(clk), .reset_n_i(rst_n), .req_data_i(req_data), .req_v_i(req_v),
      .req_ready_and_o(rdy_oh), .data_o(data), .v_o(v), .ready_and_i(ready),
      .grant_id_o(gid)
`ifdef BP_FPGA_HOST_NBF_ARB_STATS_EN
      , .grant_cnt_o(gcnt)
`endif
   );

   bp_fpga_host_nbf_tx_arbiter #(.starve_limit_p(0)) u_fx (
      .clk_i(clk), .reset_n_i(rst_n), .req_data_i(fx_data), .req_v_i(fx_v),
      .req_ready_and_o(fx_rdy_oh), .data_o(fx_dout), .v_o(fx_vo), .ready_and_i(1'b1),
      .grant_id_o(fx_gid)
`ifdef BP_FPGA_HOST_NBF_ARB_STATS_EN
      , .grant_cnt_o(fx_gcnt)
`endif
   );

   function automatic logic [111:0] mk(input int id, input int s);
      return {8'(id), 8'h5A, 96'(s)};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && v && ready) begin
         if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL pkt_unexpected act=%0h exp=none", {gid, data});
         end else
            chk("pkt", 128'({gid, data}), 128'(q.pop_front()));
      end
   end

   task automatic setdata();
      seq++;
      req_data = {mk(1, seq), mk(0, seq)};
   endtask

   // eg = expected winner this cycle, -1 = no accept
   task automatic cyc(input logic [1:0] rv, input logic rd, input int eg);
      @(posedge clk); #1;
      req_v = rv; ready = rd; setdata();
      @(negedge clk);
      chk("ready_oh", 128'(rdy_oh), (eg < 0) ? 128'd0 : (128'd1 << eg));
      if (eg >= 0) q.push_back({1'(eg), mk(eg, seq)});
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_v", 128'(v), 128'd0);
      chk("rst_ready", 128'(rdy_oh), 128'd0);
`ifdef BP_FPGA_HOST_NBF_ARB_STATS_EN
      chk("rst_gcnt", 128'(gcnt), 128'd0);
`endif
      q.delete();
      req_v = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req_v = 2'b11; ready = 1'b1; fx_v = 2'b00;
      req_data = {mk(1, 0), mk(0, 0)};
      fx_data  = {mk(1, 7), mk(0, 7)};
      // reset hold with all requesters valid
      @(negedge clk); @(negedge clk);
      chk("rst_hold_v", 128'(v), 128'd0);
      chk("rst_hold_ready", 128'(rdy_oh), 128'd0);
      chk("rst_hold_data", 128'(data), 128'd0);
      chk("rst_hold_gid", 128'(gid), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", 128'(rdy_oh), 128'd1);
      q.push_back({1'b0, mk(0, 0)});

      // single requester 1 stream
      for (int i = 0; i < 4; i++) cyc(2'b10, 1'b1, 1);

      // backpressure: held packet must not change
      for (int i = 0; i < 5; i++) begin
         cyc(2'b01, 1'b0, -1);
         chk("bp_hold", 128'(data), 128'(q[$][111:0]));
         chk("bp_v", 128'(v), 128'd1);
      end
      cyc(2'b01, 1'b1, 0);
      cyc(2'b00, 1'b1, -1);
      cyc(2'b00, 1'b1, -1);
      chk("idle_v", 128'(v), 128'd0);

      // starvation escape, limit 8: period of 9 grants
      do_reset();
      for (int i = 0; i < 27; i++) cyc(2'b11, 1'b1, (i % 9 == 8) ? 1 : 0);

      // async reset mid-stream clears the starvation count
      for (int i = 0; i < 5; i++) cyc(2'b11, 1'b1, 0);
      do_reset();
      for (int i = 0; i < 9; i++) cyc(2'b11, 1'b1, (i == 8) ? 1 : 0);
      cyc(2'b00, 1'b1, -1);
      cyc(2'b00, 1'b1, -1);
      chk("q_drained", 128'(q.size()), 128'd0);

      // pure fixed priority
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         fx_v = 2'b11;
         @(negedge clk);
         chk("fixed_ready", 128'(fx_rdy_oh), 128'd1);
         if (i > 0) chk("fixed_gid", 128'(fx_gid), 128'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
